stream_layer_seq: RTL

//  Sequencer for one streaming fully-connected layer (one input word per cycle, broadcast to all neurons).

---
 rtl/stream_layer_seq.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/stream_layer_seq.sv
// Frame sequencer for one streaming fully-connected layer: feeds words, drains, captures, hands off.
// Optional argmax scan over the captured result enabled by macro STREAM_LAYER_SEQ_ARGMAX_EN.
module stream_layer_seq #(
  parameter int NUM_WEIGHT    = 784,
  parameter int NEURON_NUMBER = 10,
  parameter int DATA_WIDTH    = 16,
  parameter int DRAIN_CYCLES  = 3,
  localparam int CLS_W = (NEURON_NUMBER > 1) ? $clog2(NEURON_NUMBER) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DATA_WIDTH-1:0]               in_data,
  input  logic                                in_valid,
  input  logic                                in_last,
  output logic                                in_ready,
  output logic [DATA_WIDTH-1:0]               layer_in,
  output logic                                layer_pause,
  output logic                                layer_freeze,
  input  logic [NEURON_NUMBER*DATA_WIDTH-1:0] layer_out,
  output logic [NEURON_NUMBER*DATA_WIDTH-1:0] res_data,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic [CLS_W-1:0]                    res_class,
  output logic                                busy,
  output logic                                frame_err
);

  localparam int BW  = $clog2(NUM_WEIGHT + 1);
  localparam int DCW = $clog2(DRAIN_CYCLES + 1);
  localparam int RW  = NEURON_NUMBER * DATA_WIDTH;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_STREAM = 3'd1;
  localparam logic [2:0] ST_DRAIN  = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
`ifdef STREAM_LAYER_SEQ_ARGMAX_EN
  localparam logic [2:0] ST_SCAN   = 3'd4;
  localparam logic [CLS_W-1:0] SCAN_LAST = CLS_W'(NEURON_NUMBER - 1);
  localparam logic [CLS_W-1:0] SCAN_ONE  = CLS_W'(1);
`endif

  localparam logic [BW-1:0]  LAST_IDX   = BW'(NUM_WEIGHT - 1);
  localparam logic [BW-1:0]  BEAT_ONE   = BW'(1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES);
  localparam logic [DCW-1:0] DRAIN_ONE  = DCW'(1);

  logic [2:0]     r_state;
  logic [BW-1:0]  r_beat_cnt;
  logic [DCW-1:0] r_drain_cnt;
  logic           w_beat;
  logic           w_word_last;
  logic [BW-1:0]  w_word_idx;

`ifdef STREAM_LAYER_SEQ_ARGMAX_EN
  logic [CLS_W-1:0]      r_scan_idx;
  logic [DATA_WIDTH-1:0] r_best;
  logic [DATA_WIDTH-1:0] w_scan_word;
  logic                  w_scan_last;
`endif

  // Handshake decode; in_ready depends on state alone so upstream never sees a valid->ready loop
  always_comb begin
    in_ready    = (r_state == ST_IDLE) || (r_state == ST_STREAM);
    busy        = (r_state != ST_IDLE);
    w_beat      = in_valid & in_ready;
    if (r_state == ST_STREAM) begin
      w_word_idx = r_beat_cnt;
    end else begin
      w_word_idx = {BW{1'b0}};
    end
    w_word_last = (w_word_idx == LAST_IDX);
  end

  // Word register towards the layer plus sticky framing check
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      layer_in    <= {DATA_WIDTH{1'b0}};
      layer_pause <= 1'b1;
      frame_err   <= 1'b0;
    end else begin
      layer_pause <= ~w_beat;
      if (w_beat) begin
        layer_in <= in_data;
        if (in_last != w_word_last) begin
          frame_err <= 1'b1;
        end
      end
    end
  end

  // Frame FSM: count beats, drain the pipeline, capture and hold the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_beat_cnt   <= {BW{1'b0}};
      r_drain_cnt  <= {DCW{1'b0}};
      res_data     <= {RW{1'b0}};
      res_valid    <= 1'b0;
      layer_freeze <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_beat) begin
            if (NUM_WEIGHT == 1) begin
              r_state    <= ST_DRAIN;
              r_beat_cnt <= {BW{1'b0}};
            end else begin
              r_state    <= ST_STREAM;
              r_beat_cnt <= BEAT_ONE;
            end
          end
        end
        ST_STREAM: begin
          if (w_beat) begin
            if (r_beat_cnt == LAST_IDX) begin
              r_state    <= ST_DRAIN;
              r_beat_cnt <= {BW{1'b0}};
            end else begin
              r_beat_cnt <= r_beat_cnt + BEAT_ONE;
            end
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == DRAIN_LAST) begin
            r_drain_cnt  <= {DCW{1'b0}};
            res_data     <= layer_out;
            layer_freeze <= 1'b1;
`ifdef STREAM_LAYER_SEQ_ARGMAX_EN
            r_state      <= ST_SCAN;
`else
            r_state      <= ST_HOLD;
            res_valid    <= 1'b1;
`endif
          end else begin
            r_drain_cnt <= r_drain_cnt + DRAIN_ONE;
          end
        end
`ifdef STREAM_LAYER_SEQ_ARGMAX_EN
        ST_SCAN: begin
          if (w_scan_last) begin
            r_state   <= ST_HOLD;
            res_valid <= 1'b1;
          end
        end
`endif
        ST_HOLD: begin
          if (res_ready) begin
            r_state      <= ST_IDLE;
            res_valid    <= 1'b0;
            layer_freeze <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          res_valid    <= 1'b0;
          layer_freeze <= 1'b0;
        end
      endcase
    end
  end

`ifdef STREAM_LAYER_SEQ_ARGMAX_EN
  // Word under inspection during the scan
  always_comb begin
    w_scan_word = res_data[DATA_WIDTH*r_scan_idx +: DATA_WIDTH];
    w_scan_last = (r_scan_idx == SCAN_LAST);
  end

  // One word per cycle, signed; strict greater-than so a tie keeps the lower index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_idx <= {CLS_W{1'b0}};
      r_best     <= {DATA_WIDTH{1'b0}};
      res_class  <= {CLS_W{1'b0}};
    end else if (r_state == ST_SCAN) begin
      if (r_scan_idx == {CLS_W{1'b0}}) begin
        r_best    <= w_scan_word;
        res_class <= {CLS_W{1'b0}};
      end else if ($signed(w_scan_word) > $signed(r_best)) begin
        r_best    <= w_scan_word;
        res_class <= r_scan_idx;
      end else begin
        r_best    <= r_best;
      end
      if (w_scan_last) begin
        r_scan_idx <= {CLS_W{1'b0}};
      end else begin
        r_scan_idx <= r_scan_idx + SCAN_ONE;
      end
    end else begin
      r_scan_idx <= {CLS_W{1'b0}};
    end
  end
`else
  assign res_class = {CLS_W{1'b0}};
`endif

endmodule
